// File: rtl/axis_chk_pkg.sv
// Shared constants and types for the AXI-Stream pattern checker.
// FSM encoding, the all-ones index value and the sticky error flag group.
package axis_chk_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    // Truncated to the counter width where used; marks "no mismatch seen".
    localparam logic [63:0] IDX_ALL_ONES = {64{1'b1}};

    typedef struct packed {
        logic data;
        logic last;
        logic strb;
    } err_flags_t;

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI-Stream handshake bundle between the memory read-out master and the checker sink.
interface axis_stream_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sat_counter.sv
// Up-counter that sticks at all ones; synchronous clear, async active-high reset.
module axis_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks an incrementing data pattern, packet length and strobes.
// state | meaning: IDLE tready low, waiting for enable | RECV accepting beats | STALL one-cycle tready gap
module axis_stream_checker
    import axis_chk_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    PKT_LEN     = 64,
    parameter logic [DATA_WIDTH-1:0] START_VALUE = '0,
    parameter int                    STALL_EVERY = 0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  s04_axis_aclk,
    input  logic                  s04_axis_areset,
    input  logic                  s04_axis_enable,
    input  logic                  s04_axis_clear,
    axis_stream_checker_if.slave  s04_axis,
    output logic [CNT_WIDTH-1:0]  chk_word_count,
    output logic [CNT_WIDTH-1:0]  chk_pkt_count,
    output logic                  chk_err_data,
    output logic                  chk_err_last,
    output logic                  chk_err_strb,
    output logic [CNT_WIDTH-1:0]  chk_first_err_idx,
    output logic                  chk_pkt_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] STALL_N  = CNT_WIDTH'(STALL_EVERY);
    localparam bit                   STALL_EN = (STALL_EVERY != 0);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  tready_q;
    logic [CNT_WIDTH-1:0]  beat_idx;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic [CNT_WIDTH-1:0]  first_err_idx;
    logic                  pkt_done;
    err_flags_t            err;

    logic                  xfer;
    logic                  at_end;
    logic                  mismatch;
    logic                  stall_hit;
    logic [DATA_WIDTH-1:0] expected;

    // A beat arriving with clear is dropped unchecked, so clear masks the transfer.
    assign xfer      = s04_axis.tvalid && tready_q && !s04_axis_clear;
    assign at_end    = (beat_idx == LAST_IDX);
    assign expected  = START_VALUE + DATA_WIDTH'(beat_idx);
    assign mismatch  = (s04_axis.tdata != expected);
    assign stall_hit = STALL_EN && xfer && ((stall_cnt + 1'b1) == STALL_N);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s04_axis_enable) state_nxt = ST_RECV;
            ST_RECV: begin
                if (!s04_axis_enable)  state_nxt = ST_IDLE;
                else if (stall_hit)    state_nxt = ST_STALL;
            end
            ST_STALL: state_nxt = s04_axis_enable ? ST_RECV : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge s04_axis_aclk or posedge s04_axis_areset) begin
        if (s04_axis_areset) begin
            state         <= ST_IDLE;
            tready_q      <= 1'b0;
            beat_idx      <= '0;
            stall_cnt     <= '0;
            err           <= '0;
            first_err_idx <= CNT_WIDTH'(IDX_ALL_ONES);
            pkt_done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            tready_q <= (state_nxt == ST_RECV);
            if (s04_axis_clear) begin
                beat_idx      <= '0;
                stall_cnt     <= '0;
                err           <= '0;
                first_err_idx <= CNT_WIDTH'(IDX_ALL_ONES);
                pkt_done      <= 1'b0;
            end else begin
                pkt_done <= xfer && s04_axis.tlast;
                if (xfer) begin
                    // tlast always resyncs the index; a missing tlast wraps it at the packet end.
                    beat_idx <= (s04_axis.tlast || at_end) ? '0 : beat_idx + 1'b1;
                    if (STALL_EN) stall_cnt <= stall_hit ? '0 : stall_cnt + 1'b1;
                    if (mismatch) begin
                        err.data <= 1'b1;
                        if (!err.data) first_err_idx <= chk_word_count;
                    end
                    if (s04_axis.tstrb != '1)        err.strb <= 1'b1;
                    if (s04_axis.tlast != at_end)    err.last <= 1'b1;
                end
            end
        end
    end

    axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_word_cnt (
        .clk   (s04_axis_aclk),
        .rst   (s04_axis_areset),
        .inc   (xfer),
        .clr   (s04_axis_clear),
        .count (chk_word_count)
    );

    axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk   (s04_axis_aclk),
        .rst   (s04_axis_areset),
        .inc   (xfer && s04_axis.tlast),
        .clr   (s04_axis_clear),
        .count (chk_pkt_count)
    );

    assign s04_axis.tready   = tready_q;
    assign chk_err_data      = err.data;
    assign chk_err_last      = err.last;
    assign chk_err_strb      = err.strb;
    assign chk_first_err_idx = first_err_idx;
    assign chk_pkt_done      = pkt_done;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Bench for axis_stream_checker: vector table, directed packet sequences and random traffic vs. a beat-level model.
module tb_axis_stream_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT A: defaults, no stalls. DUT B: stall every 4. DUT C: 4-beat packets, 4-bit counters.
    axis_stream_checker_if #(.DATA_WIDTH(32)) bus_a ();
    axis_stream_checker_if #(.DATA_WIDTH(32)) bus_b ();
    axis_stream_checker_if #(.DATA_WIDTH(32)) bus_c ();

    logic        en_a = 0, clr_a = 0, en_b = 0, clr_b = 0, en_c = 0, clr_c = 0;
    logic [15:0] wc_a, pc_a, fidx_a, wc_b, pc_b, fidx_b;
    logic [3:0]  wc_c, pc_c, fidx_c;
    logic        ed_a, el_a, es_a, done_a, ed_b, el_b, es_b, done_b, ed_c, el_c, es_c, done_c;

    axis_stream_checker #(.DATA_WIDTH(32), .PKT_LEN(64), .START_VALUE(32'h0),
                          .STALL_EVERY(0), .CNT_WIDTH(16)) dut_a (
        .s04_axis_aclk(clk), .s04_axis_areset(rst), .s04_axis_enable(en_a), .s04_axis_clear(clr_a),
        .s04_axis(bus_a), .chk_word_count(wc_a), .chk_pkt_count(pc_a), .chk_err_data(ed_a),
        .chk_err_last(el_a), .chk_err_strb(es_a), .chk_first_err_idx(fidx_a), .chk_pkt_done(done_a));

    axis_stream_checker #(.DATA_WIDTH(32), .PKT_LEN(64), .START_VALUE(32'h0),
                          .STALL_EVERY(4), .CNT_WIDTH(16)) dut_b (
        .s04_axis_aclk(clk), .s04_axis_areset(rst), .s04_axis_enable(en_b), .s04_axis_clear(clr_b),
        .s04_axis(bus_b), .chk_word_count(wc_b), .chk_pkt_count(pc_b), .chk_err_data(ed_b),
        .chk_err_last(el_b), .chk_err_strb(es_b), .chk_first_err_idx(fidx_b), .chk_pkt_done(done_b));

    axis_stream_checker #(.DATA_WIDTH(32), .PKT_LEN(4), .START_VALUE(32'hA0),
                          .STALL_EVERY(0), .CNT_WIDTH(4)) dut_c (
        .s04_axis_aclk(clk), .s04_axis_areset(rst), .s04_axis_enable(en_c), .s04_axis_clear(clr_c),
        .s04_axis(bus_c), .chk_word_count(wc_c), .chk_pkt_count(pc_c), .chk_err_data(ed_c),
        .chk_err_last(el_c), .chk_err_strb(es_c), .chk_first_err_idx(fidx_c), .chk_pkt_done(done_c));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Beat-level reference model for DUT A (START_VALUE 0, 64-beat packets, 16-bit counters).
    int m_idx = 0, m_wc = 0, m_pc = 0, m_fidx = 65535;
    bit m_ed = 0, m_el = 0, m_es = 0, m_done = 0, m_rdy = 0;

    task automatic cmp_a(input string tag);
        chk({tag, "_tready"}, 64'(bus_a.tready), 64'(m_rdy));
        chk({tag, "_words"},  64'(wc_a),   64'(m_wc));
        chk({tag, "_pkts"},   64'(pc_a),   64'(m_pc));
        chk({tag, "_errd"},   64'(ed_a),   64'(m_ed));
        chk({tag, "_errl"},   64'(el_a),   64'(m_el));
        chk({tag, "_errs"},   64'(es_a),   64'(m_es));
        chk({tag, "_fidx"},   64'(fidx_a), 64'(m_fidx));
        chk({tag, "_done"},   64'(done_a), 64'(m_done));
    endtask

    task automatic step_a(input string tag, input bit en, input bit clr, input bit v,
                          input logic [31:0] d, input logic [3:0] s, input bit l);
        bit xf;
        en_a = en; clr_a = clr;
        bus_a.tvalid = v; bus_a.tdata = d; bus_a.tstrb = s; bus_a.tlast = l;
        xf = v && m_rdy && !clr;
        @(posedge clk); #1;
        if (clr) begin
            m_idx = 0; m_wc = 0; m_pc = 0; m_fidx = 65535;
            m_ed = 0; m_el = 0; m_es = 0; m_done = 0;
        end else begin
            m_done = xf && l;
            if (xf) begin
                if (d != 32'(m_idx)) begin
                    if (!m_ed) m_fidx = m_wc;
                    m_ed = 1;
                end
                if (s != 4'hF) m_es = 1;
                if (l != (m_idx == 63)) m_el = 1;
                if (l && m_pc < 65535) m_pc++;
                if (m_wc < 65535) m_wc++;
                m_idx = (l || m_idx == 63) ? 0 : m_idx + 1;
            end
        end
        m_rdy = en;
        cmp_a(tag);
    endtask

    task automatic good_a(input string tag, input bit en, input bit clr, input bit v);
        step_a(tag, en, clr, v, 32'(m_idx), 4'hF, m_idx == 63);
    endtask

    typedef struct {
        bit          en, clr, v;
        logic [31:0] d;
        logic [3:0]  s;
        bit          l;
        bit          rdy;
        int          wc, pc;
        bit          ed, el, es, done;
        int          fidx;
    } vec_t;

    task automatic step_c(input bit en, input bit clr, input bit v,
                          input logic [31:0] d, input logic [3:0] s, input bit l);
        en_c = en; clr_c = clr;
        bus_c.tvalid = v; bus_c.tdata = d; bus_c.tstrb = s; bus_c.tlast = l;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tab[15];
        int   pulses, k, since, edges;
        bit   started, xf, stall, mrdy_b, en, clr, v, l;
        logic [31:0] d;
        logic [3:0]  s;

        bus_a.tvalid = 0; bus_a.tdata = 0; bus_a.tstrb = 0; bus_a.tlast = 0;
        bus_b.tvalid = 0; bus_b.tdata = 0; bus_b.tstrb = 0; bus_b.tlast = 0;
        bus_c.tvalid = 0; bus_c.tdata = 0; bus_c.tstrb = 0; bus_c.tlast = 0;

        // Reset values, sampled while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready_a", 64'(bus_a.tready), 64'd0);
        chk("rst_tready_b", 64'(bus_b.tready), 64'd0);
        chk("rst_words_a",  64'(wc_a), 64'd0);
        chk("rst_pkts_b",   64'(pc_b), 64'd0);
        chk("rst_flags_a",  64'({ed_a, el_a, es_a, done_a}), 64'd0);
        chk("rst_fidx_a",   64'(fidx_a), 64'hFFFF);
        chk("rst_fidx_c",   64'(fidx_c), 64'hF);
        rst = 0;

        // DUT C vector table: {en,clr,v,data,strb,last} -> {tready,words,pkts,errd,errl,errs,done,fidx}
        tab[0]  = '{1,0,1,32'hA0,4'hF,0, 1,0,0,0,0,0,0,15};
        tab[1]  = '{1,0,1,32'hA0,4'hF,0, 1,1,0,0,0,0,0,15};
        tab[2]  = '{1,0,1,32'hA1,4'hF,0, 1,2,0,0,0,0,0,15};
        tab[3]  = '{1,0,1,32'hA2,4'h7,0, 1,3,0,0,0,1,0,15};
        tab[4]  = '{1,0,1,32'hA3,4'hF,1, 1,4,1,0,0,1,1,15};
        tab[5]  = '{1,0,1,32'hA0,4'hF,1, 1,5,2,0,1,1,1,15};
        tab[6]  = '{1,0,1,32'hA0,4'hF,0, 1,6,2,0,1,1,0,15};
        tab[7]  = '{1,0,1,32'h55,4'hF,0, 1,7,2,1,1,1,0,6};
        tab[8]  = '{1,0,0,32'hA2,4'hF,0, 1,7,2,1,1,1,0,6};
        tab[9]  = '{0,0,1,32'hA2,4'hF,0, 0,8,2,1,1,1,0,6};
        tab[10] = '{0,0,1,32'hA3,4'hF,0, 0,8,2,1,1,1,0,6};
        tab[11] = '{1,0,1,32'hA3,4'hF,0, 1,8,2,1,1,1,0,6};
        tab[12] = '{1,0,1,32'hA3,4'hF,0, 1,9,2,1,1,1,0,6};
        tab[13] = '{1,1,1,32'hA0,4'hF,0, 1,0,0,0,0,0,0,15};
        tab[14] = '{1,0,1,32'hA1,4'hF,0, 1,1,0,1,0,0,0,0};
        for (int i = 0; i < 15; i++) begin
            step_c(tab[i].en, tab[i].clr, tab[i].v, tab[i].d, tab[i].s, tab[i].l);
            chk($sformatf("vec%0d_tready", i), 64'(bus_c.tready), 64'(tab[i].rdy));
            chk($sformatf("vec%0d_words", i),  64'(wc_c),   64'(tab[i].wc));
            chk($sformatf("vec%0d_pkts", i),   64'(pc_c),   64'(tab[i].pc));
            chk($sformatf("vec%0d_flags", i),  64'({ed_c, el_c, es_c}),
                64'({tab[i].ed, tab[i].el, tab[i].es}));
            chk($sformatf("vec%0d_done", i),   64'(done_c), 64'(tab[i].done));
            chk($sformatf("vec%0d_fidx", i),   64'(fidx_c), 64'(tab[i].fidx));
        end

        // DUT C: missing tlast on beat 3, then counter saturation at 15.
        step_c(1, 1, 0, 0, 4'hF, 0);
        for (int i = 0; i < 3; i++) step_c(1, 0, 1, 32'hA0 + 32'(i), 4'hF, 0);
        chk("c_no_last_yet", 64'(el_c), 64'd0);
        step_c(1, 0, 1, 32'hA3, 4'hF, 0);
        chk("c_missing_last", 64'(el_c), 64'd1);
        chk("c_missing_pkts", 64'(pc_c), 64'd0);
        for (int i = 0; i < 20; i++) step_c(1, 0, 1, 32'hA0, 4'hF, 1);
        chk("c_words_sat", 64'(wc_c), 64'hF);
        chk("c_pkts_sat",  64'(pc_c), 64'hF);
        step_c(0, 0, 0, 0, 4'hF, 0);

        // DUT B: tready gap after every 4th transfer, 64 beats in 80 cycles including the final gap.
        en_b = 1; bus_b.tstrb = 4'hF;
        k = 0; since = 0; edges = 0; started = 0; mrdy_b = 0;
        for (int c = 0; c < 300 && k < 64; c++) begin
            bus_b.tvalid = 1; bus_b.tdata = 32'(k); bus_b.tlast = (k == 63);
            xf = mrdy_b;
            @(posedge clk); #1;
            if (xf) started = 1;
            if (started) edges++;
            stall = 0;
            if (xf) begin
                k++; since++;
                if (since == 4) begin stall = 1; since = 0; end
            end
            mrdy_b = !stall;
            chk($sformatf("b_tready_c%0d", c), 64'(bus_b.tready), 64'(mrdy_b));
        end
        chk("b_beats_done", 64'(k), 64'd64);
        chk("b_cycles", 64'(edges + 1), 64'd80);
        bus_b.tvalid = 0;
        @(posedge clk); #1;
        chk("b_words", 64'(wc_b), 64'd64);
        chk("b_pkts",  64'(pc_b), 64'd1);
        chk("b_clean", 64'({ed_b, el_b, es_b}), 64'd0);

        // DUT A: one clean packet.
        good_a("a_en", 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 200 && m_wc < 64; i++) begin
            good_a("a_pkt", 1, 0, 1);
            if (done_a === 1'b1) pulses++;
        end
        good_a("a_idle", 1, 0, 0);
        if (done_a === 1'b1) pulses++;
        chk("a_pkt_words", 64'(wc_a), 64'd64);
        chk("a_pkt_pkts",  64'(pc_a), 64'd1);
        chk("a_pkt_pulses", 64'(pulses), 64'd1);
        chk("a_pkt_clean", 64'({ed_a, el_a, es_a}), 64'd0);

        // Mismatches at beats 10 and 20; only the first is indexed.
        good_a("a_clr1", 1, 1, 0);
        for (int i = 0; i < 200 && m_wc < 64; i++)
            step_a("a_bad", 1, 0, 1, (m_idx == 10 || m_idx == 20) ? 32'hDEAD0000 : 32'(m_idx),
                   4'hF, m_idx == 63);
        chk("a_bad_errd", 64'(ed_a), 64'd1);
        chk("a_bad_fidx", 64'(fidx_a), 64'd10);

        // Early tlast on beat 31, then a fresh full packet.
        good_a("a_clr2", 1, 1, 0);
        for (int i = 0; i < 200 && m_wc < 32; i++)
            step_a("a_early", 1, 0, 1, 32'(m_idx), 4'hF, m_idx == 31);
        for (int i = 0; i < 200 && m_wc < 96; i++) good_a("a_resync", 1, 0, 1);
        chk("a_early_errl", 64'(el_a), 64'd1);
        chk("a_early_pkts", 64'(pc_a), 64'd2);
        chk("a_early_errd", 64'(ed_a), 64'd0);

        // Enable dropped at beat 30 for 5 cycles with tvalid held high.
        good_a("a_clr3", 1, 1, 0);
        for (int i = 0; i < 200 && m_wc < 30; i++) good_a("a_pre", 1, 0, 1);
        repeat (5) good_a("a_off", 0, 0, 1);
        for (int i = 0; i < 200 && m_wc < 64; i++) good_a("a_post", 1, 0, 1);
        chk("a_off_words", 64'(wc_a), 64'd64);
        chk("a_off_pkts",  64'(pc_a), 64'd1);
        chk("a_off_clean", 64'({ed_a, el_a, es_a}), 64'd0);

        // Clear together with the transfer of beat 5.
        good_a("a_clr4", 1, 1, 0);
        for (int i = 0; i < 200 && m_wc < 5; i++) good_a("a_pre5", 1, 0, 1);
        good_a("a_clrbeat", 1, 1, 1);
        for (int i = 0; i < 200 && m_wc < 64; i++) good_a("a_fresh", 1, 0, 1);
        chk("a_clr_words", 64'(wc_a), 64'd64);
        chk("a_clr_flags", 64'({ed_a, el_a, es_a}), 64'd0);
        chk("a_clr_fidx",  64'(fidx_a), 64'hFFFF);

        // Random traffic against the model.
        good_a("a_clr5", 1, 1, 0);
        for (int i = 0; i < 800; i++) begin
            en  = ($urandom % 12) != 0;
            clr = ($urandom % 150) == 0;
            v   = ($urandom % 4) != 0;
            d   = (($urandom % 25) == 0) ? $urandom : 32'(m_idx);
            s   = (($urandom % 30) == 0) ? 4'($urandom) : 4'hF;
            l   = (m_idx == 63);
            if (($urandom % 40) == 0) l = !l;
            step_a("a_rnd", en, clr, v, d, s, l);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_stream_checker.md
# axis_stream_checker

AXI-Stream sink terminating the memory read-out stream (m03 side of the generator/memory chain). It accepts beats under its own tready control and checks each beat against an expected incrementing pattern, the packet length and the strobes. It counts accepted words and packets and holds sticky error flags for the bench and for on-board status. The optional periodic tready stall exercises the upstream master's backpressure path.

## Interface
- DATA_WIDTH, 32, tdata width; tstrb is DATA_WIDTH/8
- PKT_LEN, 64, beats per packet; tlast is expected on beat PKT_LEN-1
- START_VALUE, 0, expected tdata of beat 0 of every packet
- STALL_EVERY, 0, deassert tready for one cycle after every N accepted beats; 0 disables stalling
- CNT_WIDTH, 16, width of the counters and of the error index

- s04_axis_aclk  in  1  sole clock, rising edge
- s04_axis_areset  in  1  asynchronous, active-high reset
- s04_axis_enable  in  1  level enable; low forces tready low
- s04_axis_clear  in  1  synchronous clear of counters, flags and beat index
- s04_axis_tdata  in  DATA_WIDTH  stream data
- s04_axis_tstrb  in  DATA_WIDTH/8  byte strobes
- s04_axis_tvalid  in  1  upstream valid
- s04_axis_tlast  in  1  end of packet
- s04_axis_tready  out  1  registered ready
- chk_word_count  out  CNT_WIDTH  accepted beats, saturating
- chk_pkt_count  out  CNT_WIDTH  packets closed by tlast, saturating
- chk_err_data  out  1  sticky; tdata mismatch seen
- chk_err_last  out  1  sticky; tlast early or missing
- chk_err_strb  out  1  sticky; tstrb not all ones on an accepted beat
- chk_first_err_idx  out  CNT_WIDTH  chk_word_count value at the first data mismatch; all ones if none
- chk_pkt_done  out  1  one-cycle pulse after a beat accepted with tlast

## Operation
- A transfer occurs on a rising edge where tvalid and tready are both high. Only transfers update state.
- States:
  - IDLE: tready=0. Moves to RECV when enable=1.
  - RECV: tready=1. Moves to STALL when a transfer brings the stall counter to STALL_EVERY and STALL_EVERY≠0. Moves to IDLE when enable=0.
  - STALL: tready=0 for exactly one cycle, then returns to RECV, or to IDLE if enable=0.
- Expected data is START_VALUE + beat_idx, taken modulo 2^DATA_WIDTH. beat_idx is CNT_WIDTH wide and counts within the packet.
- On every transfer:
  - word_count increments.
  - A tdata mismatch sets err_data. The first mismatch only also latches first_err_idx with the pre-increment word_count.
  - tstrb ≠ all ones sets err_strb. The data is still compared.
- tlast handling:
  - tlast at beat_idx=PKT_LEN-1: beat_idx returns to 0, pkt_count increments, pkt_done pulses.
  - tlast at beat_idx<PKT_LEN-1 (early): err_last sets. beat_idx returns to 0, pkt_count increments and pkt_done pulses anyway, so the checker resyncs on tlast.
  - No tlast at beat_idx=PKT_LEN-1 (missing): err_last sets. beat_idx wraps to 0. pkt_count and pkt_done are unaffected.
- Counters saturate at all ones and never wrap.
- enable low mid-packet: tready drops on the next edge. beat_idx, counters and flags hold, and checking resumes in place when enable returns.
- clear has priority over a same-cycle transfer; that beat is discarded and not checked. clear resets:
  - counters, flags and beat_idx to 0
  - the stall counter to 0
  - first_err_idx to all ones
- clear does not change the FSM state.
- Async reset: FSM to IDLE. All outputs return to their reset values (see Timing).

## Timing
- Reset values: tready=0, counts=0, all err flags=0, pkt_done=0, first_err_idx=all ones.
- tready is registered: it rises one edge after enable rises and falls one edge after enable falls. A beat presented while tready is low is not accepted.
- Counters and flags update on the edge of the transfer and are visible in the following cycle. pkt_done is high for exactly that following cycle.
- Sustained throughput is 1 beat/cycle with STALL_EVERY=0, and N beats per N+1 cycles with STALL_EVERY=N.
- No combinational path from any input to any output.

## Structure
- Package axis_chk_pkg holds the FSM state encoding (IDLE, RECV, STALL) and the all-ones index constant.
- One sub-module, axis_sat_counter (parameter WIDTH; inputs inc, clr). It is instantiated for word_count and pkt_count.
- Beat index, stall counter and compare logic stay in the top module.

## Test plan
- Reset, enable=1, one 64-beat packet 0..63 with tlast on beat 63 -> word_count=64, pkt_count=1, pkt_done pulses once, all err flags 0.
- Beat 10 carries 0xDEAD0000 -> err_data=1, first_err_idx=10. A later mismatch at beat 20 leaves first_err_idx at 10.
- tlast on beat 31 followed by a fresh 0..63 packet -> err_last=1, pkt_count=2, err_data stays 0.
- STALL_EVERY=4, tvalid held high for 64 beats -> tready low one cycle after every 4th transfer, 80 cycles total, data clean.
- enable dropped at beat 30 for 5 cycles with tvalid held high -> no beats accepted while tready=0, packet completes cleanly, word_count=64.
- clear asserted together with the transfer of beat 5, then a new 0..63 packet -> beat discarded, word_count=64, flags 0, first_err_idx=all ones.
